// File: rtl/pid_pkg.sv
// pid_pkg: shared saturation helper, bounds and default gains for the PID pipeline
package pid_pkg;
    localparam int DEF_ERR_W = 10;
    localparam int DEF_OUT_W = 12;
    localparam int ERR_MAX = (1 << (DEF_ERR_W - 1)) - 1;
    localparam int ERR_MIN = -ERR_MAX - 1;
    localparam int OUT_MAX = (1 << (DEF_OUT_W - 1)) - 1;
    localparam int OUT_MIN = -OUT_MAX - 1;
    localparam int DEF_P_COEFF = 5;
    localparam int DEF_I_SHIFT = 6;
    localparam int DEF_D_SHIFT = 6;

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        return v > hi ? hi : v < -hi - 32'sd1 ? -hi - 32'sd1 : v;
    endfunction
endpackage

// File: rtl/pid_integrator.sv
// pid_integrator: error accumulator with synchronous clear and overflow hold
module pid_integrator import pid_pkg::*; #(
    parameter int INT_W = 18,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [ERR_W-1:0] err,
    output logic signed [INT_W-1:0] integ
);
    logic signed [INT_W-1:0] err_x, sum;
    logic ovf;

    assign err_x = INT_W'(err);
    assign sum = integ + err_x;
    // same-sign operands with a flipped result sign means the add wrapped
    assign ovf = (integ[INT_W-1] == err_x[INT_W-1]) && (sum[INT_W-1] != integ[INT_W-1]);

    always_ff @(posedge clk) begin
        if (rst || clr) integ <= '0;
        else if (en && !ovf) integ <= sum;
    end
endmodule

// File: rtl/pid_ctrl_pipe.sv
// pid_ctrl_pipe: three-stage pipelined PID pitch controller with owned integrator
module pid_ctrl_pipe import pid_pkg::*; #(
    parameter int PTCH_W  = 16,
    parameter int INT_W   = 18,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int ERR_W   = DEF_ERR_W,
    parameter int P_COEFF = DEF_P_COEFF,
    parameter int I_SHIFT = DEF_I_SHIFT,
    parameter int D_SHIFT = DEF_D_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic signed [PTCH_W-1:0] ptch,
    input  logic signed [PTCH_W-1:0] ptch_rt,
    input  logic                     int_clr,
    output logic signed [OUT_W-1:0]  pid_cntrl,
    output logic                     out_vld,
    output logic                     sat,
    output logic signed [INT_W-1:0]  integ
);
    localparam int SW = OUT_W + 2;

    logic signed [ERR_W-1:0]  err_sat, err_q;
    logic signed [PTCH_W-1:0] rt_q;
    logic signed [INT_W-1:0]  int_q;
    logic signed [SW-1:0]     p_q, i_q, d_q, sum;
    logic v1, v2;

    assign err_sat = ERR_W'(sat_signed(32'(ptch), ERR_W));
    assign sum = p_q + i_q + d_q;

    pid_integrator #(.INT_W(INT_W), .ERR_W(ERR_W)) u_integ (
        .clk   (clk),
        .rst   (rst),
        .en    (in_vld),
        .clr   (int_clr),
        .err   (err_sat),
        .integ (integ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_vld <= 1'b0;
            pid_cntrl <= '0;
            sat <= 1'b0;
        end else begin
            v1 <= in_vld;
            v2 <= v1;
            out_vld <= v2;
            if (v2) begin
                pid_cntrl <= OUT_W'(sat_signed(32'(sum), OUT_W));
                sat <= sat_signed(32'(sum), OUT_W) != 32'(sum);
            end
        end
    end

    // datapath needs no reset: nothing reaches the outputs without a valid bit
    always_ff @(posedge clk) begin
        if (in_vld) begin
            err_q <= err_sat;
            rt_q <= ptch_rt;
            int_q <= integ;
        end
        if (v1) begin
            p_q <= SW'(err_q) * SW'(P_COEFF);
            i_q <= SW'(int_q >>> I_SHIFT);
            d_q <= -SW'(rt_q >>> D_SHIFT);
        end
    end
endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// tb_pid_ctrl_pipe: directed stimulus with a scoreboard of expected pid_cntrl/sat results
module tb_pid_ctrl_pipe;
    import pid_pkg::*;

    localparam int INT_MAX = (1 << 17) - 1;
    localparam int INT_MIN = -INT_MAX - 1;

    typedef struct {
        int   due;
        int   pid;
        logic sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_vld = 1'b0;
    logic int_clr = 1'b0;
    logic signed [15:0] ptch = '0;
    logic signed [15:0] ptch_rt = '0;
    logic signed [11:0] pid_cntrl;
    logic out_vld, sat;
    logic signed [17:0] integ;

    exp_t sb[$];
    int cyc = 0;
    int checks = 0;
    int passed = 0;
    int m_int = 0;
    int last_pid = 0;
    logic last_sat = 1'b0;

    pid_ctrl_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .int_clr   (int_clr),
        .pid_cntrl (pid_cntrl),
        .out_vld   (out_vld),
        .sat       (sat),
        .integ     (integ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // one clock of stimulus; the expectation is computed from plain integer arithmetic
    task automatic step(input logic vld, input int p, input int r, input logic clr);
        int e, s, o, n;
        @(posedge clk);
        #2;
        in_vld = vld;
        ptch = 16'(p);
        ptch_rt = 16'(r);
        int_clr = clr;
        e = p > ERR_MAX ? ERR_MAX : p < ERR_MIN ? ERR_MIN : p;
        if (vld) begin
            s = e * 5 + (m_int >>> 6) - (r >>> 6);
            o = s > OUT_MAX ? OUT_MAX : s < OUT_MIN ? OUT_MIN : s;
            sb.push_back('{due: cyc + 3, pid: o, sat: s != o});
        end
        n = m_int + e;
        if (clr) m_int = 0;
        else if (vld && n <= INT_MAX && n >= INT_MIN) m_int = n;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            check("out_vld_pulse", 32'(out_vld), 1);
            check("pid_cntrl", pid_cntrl, sb[0].pid);
            check("sat", 32'(sat), 32'(sb[0].sat));
            last_pid = sb[0].pid;
            last_sat = sb[0].sat;
            void'(sb.pop_front());
        end else begin
            check("out_vld_idle", 32'(out_vld), 0);
            check("pid_hold", pid_cntrl, last_pid);
            check("sat_hold", 32'(sat), 32'(last_sat));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_pid", pid_cntrl, 0);
        check("rst_sat", 32'(sat), 0);
        check("rst_integ", integ, 0);
        check("rst_vld", 32'(out_vld), 0);

        step(1'b1, 64, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("t1_integ", integ, 64);
        idle(4);

        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 0, 16384, 1'b0);
        idle(4);

        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 32767, 0, 1'b0);
        step(1'b1, -32768, 32767, 1'b0);
        idle(4);

        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 0, -32768, 1'b0);
        idle(4);

        step(1'b0, 0, 0, 1'b1);
        repeat (64) step(1'b1, 256, 0, 1'b0);
        step(1'b1, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("t4_integ", integ, 16384);
        idle(4);

        step(1'b0, 0, 0, 1'b1);
        repeat (256) step(1'b1, 32767, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("t5_integ_full", integ, 130816);
        step(1'b1, 32767, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("t5_integ_hold", integ, 130816);
        step(1'b1, 32767, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        check("t5_integ_clr", integ, 0);
        idle(4);

        step(1'b1, 100, 50, 1'b0);
        step(1'b1, -200, -70, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        m_int = 0;
        last_pid = 0;
        last_sat = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        idle(5);
        check("t6_pid", pid_cntrl, 0);
        check("t6_sat", 32'(sat), 0);
        check("t6_integ", integ, 0);
        step(1'b1, 64, 0, 1'b0);
        idle(6);

        check("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
